// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
// Contents: fetch_state_t (fetch FSM states), instr_word_t (raw instruction word),
//           RESET_PC_DEFAULT (default first fetch address), PC_INCR (sequential step).
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_DISCARD,
    ST_HALT
  } fetch_state_t;

  typedef logic [31:0] instr_word_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - skid_buffer_port valid/ready/data handshake toward the decoder
// Signals: valid (producer has a word), ready (consumer accepts), data[31:0] (word).
// Modports: downstream = producer side (drives valid/data), upstream = consumer side.
interface skid_buffer_port;

  logic        valid;
  logic        ready;
  logic [31:0] data;

  modport downstream (output valid, output data, input ready);
  modport upstream   (input valid, input data, output ready);

endinterface

// File: rtl/fetch_unit_queue.sv
// rtl/fetch_unit_queue.sv - fetch_queue: parameterised synchronous FIFO for fetched words
// Ports: clock, reset (async active-low), push/push_data, pop, flush (beats push),
//        full, empty, count (occupancy), head (oldest entry, valid when !empty).
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full queue is only accepted when the head leaves the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding memory reads, 2-entry queue
// Ports: clock, reset (async active-low); to_decode (skid_buffer_port.downstream);
//        mem_req/mem_addr/mem_ack/mem_rdata (word read port); redirect_valid/redirect_target
//        (from execute); fetch_error (halted on a misaligned redirect target).
// Build option: FETCH_MISALIGN_TRAP_EN - misaligned targets halt fetch instead of being aligned down.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  skid_buffer_port.downstream to_decode,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  instr_word_t mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_error
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t state_q, state_n;
  logic [31:0]  pc_q, pc_n;
  logic [31:0]  kill_addr_q;
  logic         err_q, err_n;
  logic         req_raw;
  logic         ack;
  logic [31:0]  redir_pc;
  logic         redir_bad;

  logic          q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0] q_count;
  instr_word_t   q_head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_pc    = redirect_target;
  assign redir_bad   = (redirect_target[1:0] != 2'b00);
  assign fetch_error = err_q;
`else
  assign redir_pc    = redirect_target & ~32'h3;
  assign redir_bad   = 1'b0;
  assign fetch_error = 1'b0;
`endif

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(32)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data (mem_rdata),
    .pop       (q_pop),
    .flush     (q_flush),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

  assign to_decode.valid = !q_empty;
  assign to_decode.data  = q_head;
  assign q_pop           = !q_empty && to_decode.ready;

  // Nothing is in flight while in ISSUE, so room in the queue alone gates a new request;
  // a request, once raised, keeps its reserved slot because the queue can only drain meanwhile.
  always_comb begin
    req_raw = 1'b0;
    case (state_q)
      ST_ISSUE:   req_raw = (q_count < CW'(QUEUE_DEPTH));
      ST_WAIT:    req_raw = 1'b1;
      ST_DISCARD: req_raw = 1'b1;
      default:    req_raw = 1'b0;
    endcase
  end

  // Reset is held combinationally here so the request line is low while reset is asserted.
  assign mem_req  = reset && req_raw;
  assign ack      = mem_req && mem_ack;
  // The killed request keeps its original address until its ack arrives.
  assign mem_addr = ((state_q == ST_DISCARD) ? kill_addr_q : pc_q) & ~32'h3;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    err_n   = err_q;
    q_push  = 1'b0;
    q_flush = 1'b0;
    if (redirect_valid) begin
      // Any same-edge ack is dropped; a handshake on this edge already popped via q_pop.
      q_flush = 1'b1;
      pc_n    = redir_pc;
      err_n   = redir_bad;
      if (mem_req && !ack) state_n = ST_DISCARD;
      else                 state_n = redir_bad ? ST_HALT : ST_ISSUE;
    end else begin
      case (state_q)
        ST_ISSUE, ST_WAIT: begin
          if (ack) begin
            q_push  = !q_full || q_pop;
            pc_n    = pc_q + PC_INCR;
            state_n = ST_ISSUE;
          end else if (mem_req) begin
            state_n = ST_WAIT;
          end
        end
        ST_DISCARD: if (ack) state_n = err_q ? ST_HALT : ST_ISSUE;
        ST_HALT:    state_n = ST_HALT;
        default:    state_n = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ISSUE;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      err_q   <= err_n;
      if (state_q != ST_DISCARD) kill_addr_q <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural memory and decode model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        fetch_error;

  skid_buffer_port dec_if ();

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .to_decode       (dec_if),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_error     (fetch_error)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  int          n_dec;
  int          lat_lo, lat_hi, lat_cnt;
  bit          lat_armed;
  int          new_reqs;
  logic [31:0] new_req_addr;
  int          rdy_mode;
  bit          redir_now;
  logic [31:0] redir_tgt;
  int          n0, n1, guard;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return t & ~32'h3;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: act as memory and decoder, advance the reference stream, then check
  // request/data stability across the edge.
  task automatic cycle();
    logic        ack, hs, pend, hold, redir;
    logic [31:0] paddr, pdata;
    ack = 1'b0;
    if (mem_req) begin
      if (!lat_armed) begin
        lat_armed    = 1'b1;
        lat_cnt      = $urandom_range(lat_hi, lat_lo);
        new_reqs++;
        new_req_addr = mem_addr;
        chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      end
      if (lat_cnt == 0) begin
        ack       = 1'b1;
        lat_armed = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
    mem_ack         = ack;
    mem_rdata       = ack ? word_at(mem_addr) : $urandom();
    dec_if.ready    = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : 1'(rdy_mode);
    redir           = redir_now;
    redirect_valid  = redir;
    redirect_target = redir_tgt;
    hs = dec_if.valid && dec_if.ready;
    if (hs) begin
      chk("decode_word", dec_if.data, word_at(exp_pc));
      exp_pc += 32'd4;
      n_dec++;
    end
    if (redir) exp_pc = eff_target(redir_tgt);
    pend  = mem_req && !ack;
    paddr = mem_addr;
    hold  = dec_if.valid && !dec_if.ready && !redir;
    pdata = dec_if.data;
    @(posedge clock);
    @(negedge clock);
    redir_now      = 1'b0;
    redirect_valid = 1'b0;
    if (pend)  chk("req_hold", mem_req ? mem_addr : 32'hDEAD_BEEF, paddr);
    if (hold)  chk("data_hold", dec_if.valid ? dec_if.data : ~pdata, pdata);
    if (redir) chk("valid_after_redirect", {31'b0, dec_if.valid}, 32'h0);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redir_now = 1'b1;
    redir_tgt = t;
    cycle();
  endtask

  initial begin
    lat_lo = 0; lat_hi = 0; rdy_mode = 1;
    exp_pc = 32'h0; n_dec = 0; new_reqs = 0; lat_armed = 1'b0; lat_cnt = 0;
    redir_now = 1'b0; redir_tgt = 32'h0; new_req_addr = 32'h0;
    dec_if.ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_valid", {31'b0, dec_if.valid}, 32'h0);
    chk("reset_req",   {31'b0, mem_req}, 32'h0);
    chk("reset_err",   {31'b0, fetch_error}, 32'h0);
    reset = 1'b1;
    #1;
    chk("first_req", {31'b0, mem_req}, 32'h1);

    // Zero-wait memory, ready decoder: sequential addresses, one word per cycle
    for (int k = 0; k < 8; k++) begin
      chk("seq_addr", mem_addr, 32'(4 * k));
      if (k >= 1) chk("stream_valid", {31'b0, dec_if.valid}, 32'h1);
      cycle();
    end

    // Back-pressure: queue fills, request drops, head holds word@0
    do_redirect(32'h0);
    rdy_mode = 0;
    repeat (10) cycle();
    chk("full_no_req", {31'b0, mem_req}, 32'h0);
    chk("hold_valid",  {31'b0, dec_if.valid}, 32'h1);
    chk("hold_data",   dec_if.data, word_at(32'h0));
    n0 = n_dec;
    rdy_mode = 1;
    repeat (6) cycle();
    chk("drain_count", 32'(n_dec - n0 >= 3), 32'h1);

    // Redirect with nothing outstanding: request at target in the very next cycle
    rdy_mode = 0;
    repeat (4) cycle();
    chk("idle_no_req", {31'b0, mem_req}, 32'h0);
    do_redirect(32'h80);
    chk("fast_redir_req",  {31'b0, mem_req}, 32'h1);
    chk("fast_redir_addr", mem_addr, 32'h80);
    rdy_mode = 1;
    repeat (4) cycle();

    // 3-cycle memory, redirect to 0x100 in the second wait cycle
    lat_lo = 3; lat_hi = 3;
    guard = 0;
    while (!(mem_req && lat_armed && lat_cnt == 1) && guard < 30) begin
      cycle();
      guard++;
    end
    chk("kill_setup", 32'(mem_req && lat_armed && lat_cnt == 1), 32'h1);
    n0 = new_reqs;
    do_redirect(32'h100);
    guard = 0;
    while (new_reqs == n0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("kill_next_addr", new_req_addr, 32'h100);
    n1 = n_dec;
    guard = 0;
    while (n_dec == n1 && guard < 30) begin
      cycle();
      guard++;
    end
    chk("kill_decoded", 32'(n_dec > n1), 32'h1);

    // Redirect on the same edge as an ack and a decoder handshake
    lat_lo = 0; lat_hi = 0;
    repeat (3) cycle();
    chk("same_edge_valid", {31'b0, dec_if.valid}, 32'h1);
    chk("same_edge_req",   {31'b0, mem_req}, 32'h1);
    do_redirect(32'h40);
    chk("same_edge_addr", mem_addr, 32'h40);
    repeat (3) cycle();

    // PC wrap-around
    do_redirect(32'hFFFF_FFFC);
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr1", mem_addr, 32'h0000_0000);
    repeat (3) cycle();

    // Misaligned redirect target
    do_redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_err",   {31'b0, fetch_error}, 32'h1);
    chk("trap_req",   {31'b0, mem_req}, 32'h0);
    chk("trap_valid", {31'b0, dec_if.valid}, 32'h0);
    repeat (3) cycle();
    chk("trap_err_sticky", {31'b0, fetch_error}, 32'h1);
    chk("trap_req_idle",   {31'b0, mem_req}, 32'h0);
    do_redirect(32'h200);
    chk("resume_addr", mem_addr, 32'h200);
    chk("resume_req",  {31'b0, mem_req}, 32'h1);
    chk("resume_err",  {31'b0, fetch_error}, 32'h0);
`else
    chk("align_addr", mem_addr, 32'h100);
    chk("align_req",  {31'b0, mem_req}, 32'h1);
    chk("align_err",  {31'b0, fetch_error}, 32'h0);
`endif
    repeat (4) cycle();

    // Randomised traffic: random latency, random ready, occasional redirects
    rdy_mode = 2; lat_lo = 0; lat_hi = 3;
    n0 = n_dec;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        redir_now = 1'b1;
        redir_tgt = $urandom() & 32'h0000_0FFC;
`else
        redir_now = 1'b1;
        redir_tgt = $urandom() & 32'h0000_0FFF;
`endif
      end
      cycle();
    end
    chk("random_progress", 32'(n_dec - n0 > 60), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
